// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the arbiter request queue.
package arb_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef logic client_id_t;

  // Ceiling log2, used to size FIFO pointers from DEPTH.
  function automatic int arb_clog2(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// Per-client ring buffer. Reports occupancy, push_ready and the head entry;
// the caller only asserts pop when the FIFO is non-empty.
module arb_client_fifo
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = arb_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              push_ready,
  output logic [PTR_W:0]    count,
  output logic [DATA_W-1:0] head
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;

  // Readiness comes from the registered count only, so a same-cycle pop
  // never frees a slot for a same-cycle push.
  assign push_ready = (count < FULL_CNT);
  assign push_ok    = push_valid && push_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Two-client request front-end for the arbiter: buffers pushes, raises
// request from occupancy, pops on legal grant. Optional ARB_Q_STATS_EN adds counters.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        push_valid,
  output logic [1:0]        push_ready,
  input  logic [DATA_W-1:0] push_data0,
  input  logic [DATA_W-1:0] push_data1,
  output logic [1:0]        request,
  input  logic [1:0]        grant,
  output logic              out_valid,
  output client_id_t        out_src,
  output logic [DATA_W-1:0] out_data,
  output logic              grant_err
`ifdef ARB_Q_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int PTR_W = arb_clog2(DEPTH);

  // Handshakes: a push on client i transfers at a rising edge when
  // push_valid[i] && push_ready[i]; out_valid is a one-cycle pulse with no
  // ready, so the consumer must take every pulse.

  logic [PTR_W:0]    count [NUM_CLIENTS];
  logic [DATA_W-1:0] head  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata [NUM_CLIENTS];
  logic [1:0]        nonempty;
  logic [1:0]        pop;
  logic              grant_illegal;

  assign wdata[0] = push_data0;
  assign wdata[1] = push_data1;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_fifo
    arb_client_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_valid (push_valid[i]),
      .push_data  (wdata[i]),
      .pop        (pop[i]),
      .push_ready (push_ready[i]),
      .count      (count[i]),
      .head       (head[i])
    );
  end

  // The entry being popped is withheld from request so the arbiter cannot
  // grant it again next cycle; grant is registered in the arbiter, so no loop.
  always_comb begin
    nonempty      = '0;
    pop           = '0;
    request       = '0;
    nonempty[0]   = (count[0] != '0);
    nonempty[1]   = (count[1] != '0);
    pop[0]        = grant[0] && !grant[1] && nonempty[0];
    pop[1]        = grant[1] && !grant[0] && nonempty[1];
    request[0]    = (count[0] - {{PTR_W{1'b0}}, pop[0]}) != '0;
    request[1]    = (count[1] - {{PTR_W{1'b0}}, pop[1]}) != '0;
    grant_illegal = (&grant) || (grant[0] && !nonempty[0])
                             || (grant[1] && !nonempty[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_src   <= 1'b0;
      out_data  <= '0;
      grant_err <= 1'b0;
    end else begin
      grant_err <= grant_illegal;
      out_valid <= |pop;
      if (|pop) begin
        out_src  <= client_id_t'(pop[1]);
        out_data <= pop[1] ? head[1] : head[0];
      end
    end
  end

`ifdef ARB_Q_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      err_cnt  <= '0;
    end else begin
      if (pop[0])        gnt_cnt0 <= sat_inc(gnt_cnt0);
      if (pop[1])        gnt_cnt1 <= sat_inc(gnt_cnt1);
      if (grant_illegal) err_cnt  <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: directed scenarios then randomized traffic,
// checked against a queue-based model of the two client FIFOs.
module tb_arb_req_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [1:0]        push_valid = '0;
  logic [1:0]        push_ready;
  logic [DATA_W-1:0] push_data0 = '0;
  logic [DATA_W-1:0] push_data1 = '0;
  logic [1:0]        request;
  logic [1:0]        grant = '0;
  logic              out_valid;
  logic              out_src;
  logic [DATA_W-1:0] out_data;
  logic              grant_err;
`ifdef ARB_Q_STATS_EN
  logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1, err_cnt;
`endif

  arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data0 (push_data0),
    .push_data1 (push_data1),
    .request    (request),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_src    (out_src),
    .out_data   (out_data),
    .grant_err  (grant_err)
`ifdef ARB_Q_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one queue per client plus the expected registered outputs.
  logic [DATA_W-1:0] mq0 [$];
  logic [DATA_W-1:0] mq1 [$];
  logic              exp_valid, exp_src, exp_err;
  logic [DATA_W-1:0] exp_data;
  logic [1:0]        last_req;
  logic [CNT_W-1:0]  exp_g0, exp_g1, exp_e;
  int                n_cmp = 0;
  int                n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] model_sat(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    exp_valid = 1'b0;
    exp_src   = 1'b0;
    exp_data  = '0;
    exp_err   = 1'b0;
    last_req  = '0;
    exp_g0    = '0;
    exp_g1    = '0;
    exp_e     = '0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({pfx, "_out_src"},   32'(out_src),   32'(exp_src));
    check({pfx, "_out_data"},  32'(out_data),  32'(exp_data));
    check({pfx, "_grant_err"}, 32'(grant_err), 32'(exp_err));
`ifdef ARB_Q_STATS_EN
    check({pfx, "_gnt_cnt0"}, 32'(gnt_cnt0), 32'(exp_g0));
    check({pfx, "_gnt_cnt1"}, 32'(gnt_cnt1), 32'(exp_g1));
    check({pfx, "_err_cnt"},  32'(err_cnt),  32'(exp_e));
`endif
  endtask

  // Reset asserted with grant g still applied, to model reset in mid-pop.
  task automatic do_reset(input logic [1:0] g);
    push_valid = '0;
    grant      = g;
    reset_n    = 1'b0;
    model_clear();
    #1;
    check_regs("rst_async");
    @(posedge clk);
    #1;
    check_regs("rst_held");
    check("rst_request",    32'(request),    32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd3);
    grant   = '0;
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check registers.
  task automatic step(input logic [1:0] pv, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] d1, input logic [1:0] g);
    int s0, s1;
    logic [1:0] pr, pp, rq;
    logic err;
    push_valid = pv;
    push_data0 = d0;
    push_data1 = d1;
    grant      = g;
    s0 = mq0.size();
    s1 = mq1.size();
    pr = {s1 < DEPTH, s0 < DEPTH};
    pp[0] = (g == 2'b01) && (s0 > 0);
    pp[1] = (g == 2'b10) && (s1 > 0);
    rq[0] = (s0 - int'(pp[0])) > 0;
    rq[1] = (s1 - int'(pp[1])) > 0;
    err   = (g == 2'b11) || (g[0] && s0 == 0) || (g[1] && s1 == 0);
    #1;
    check("push_ready", 32'(push_ready), 32'(pr));
    check("request",    32'(request),    32'(rq));
    @(posedge clk);
    exp_valid = 1'b0;
    if (pp[0]) begin
      exp_valid = 1'b1; exp_src = 1'b0; exp_data = mq0.pop_front();
      exp_g0 = model_sat(exp_g0);
    end else if (pp[1]) begin
      exp_valid = 1'b1; exp_src = 1'b1; exp_data = mq1.pop_front();
      exp_g1 = model_sat(exp_g1);
    end
    if (pv[0] && pr[0]) mq0.push_back(d0);
    if (pv[1] && pr[1]) mq1.push_back(d1);
    exp_err = err;
    if (err) exp_e = model_sat(exp_e);
    last_req = rq;
    #1;
    check_regs("step");
  endtask

  logic [DATA_W-1:0] seq [8];
  logic [1:0]        g;
  int                rg;

  initial begin
    seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    #2;
    do_reset(2'b00);

    // Idle after reset.
    for (int i = 0; i < 10; i++) step(2'b00, '0, '0, 2'b00);

    // Single transaction on client 0.
    step(2'b01, 8'hA5, '0, 2'b00);
    step(2'b00, '0, '0, 2'b01);
    check("t2_out", {out_valid, out_src, out_data}, {23'd0, 1'b1, 1'b0, 8'hA5});
    step(2'b00, '0, '0, 2'b00);

    // Fill both FIFOs, then drain with alternating grants.
    for (int i = 0; i < DEPTH; i++)
      step(2'b11, 8'h10 + 8'(i), 8'h20 + 8'(i), 2'b00);
    check("t3_full_ready", 32'(push_ready), 32'd0);
    check("t3_full_req",   32'(request),    32'd3);
    for (int k = 0; k < 8; k++) begin
      step(2'b00, '0, '0, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t3_seq", 32'(out_data), 32'(seq[k]));
    end
    step(2'b00, '0, '0, 2'b00);

    // Illegal grants.
    do_reset(2'b00);
    step(2'b00, '0, '0, 2'b11);
    step(2'b00, '0, '0, 2'b10);
    step(2'b00, '0, '0, 2'b00);
`ifdef ARB_Q_STATS_EN
    check("t4_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Reset while client 1 is mid-pop.
    for (int i = 0; i < 3; i++) step(2'b10, '0, 8'h30 + 8'(i), 2'b00);
    step(2'b00, '0, '0, 2'b10);
    do_reset(2'b10);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, 2'b00);

    // Push and pop on a full FIFO in the same cycle.
    for (int i = 0; i < DEPTH; i++) step(2'b01, 8'h40 + 8'(i), '0, 2'b00);
    step(2'b01, 8'h50, '0, 2'b01);
    step(2'b01, 8'h51, '0, 2'b00);
    for (int i = 0; i < DEPTH; i++) step(2'b00, '0, '0, 2'b01);
    check("t6_last", 32'(out_data), 32'h51);
    step(2'b00, '0, '0, 2'b00);

    // Randomized traffic with an arbiter-like grant source and some illegal grants.
    for (int n = 0; n < 3000; n++) begin
      rg = $urandom_range(0, 9);
      if (rg < 7) begin
        if (last_req == 2'b11) g = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        else                   g = last_req;
      end else begin
        g = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) do_reset(g);
      else step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
